// File: rtl/rs_issue_queue.sv
// ============================================================================
// Module   : rs_issue_queue (with package rs_issue_queue_pkg)
// Purpose  : Eight-entry reservation station with CDB wakeup and a registered
//            single-entry issue stage. Define RS_OLDEST_FIRST_EN for
//            oldest-ready selection through an age matrix.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package rs_issue_queue_pkg;
    localparam int RS_XLEN  = 32;
    localparam int RS_TAG_W = 4;

    typedef struct packed {
        logic [RS_XLEN-1:0]  vj;
        logic [RS_XLEN-1:0]  vk;
        logic [RS_TAG_W-1:0] qj;
        logic [RS_TAG_W-1:0] qk;
        logic [RS_XLEN-1:0]  store_imm;
        logic [RS_TAG_W-1:0] rob_tag;
        logic [3:0]          alu_ctrl;
        logic [2:0]          fu_type;
        logic [2:0]          branch_type;
        logic                branch;
        logic                load;
        logic                store;
    } rs_scheduler_s;
endpackage

module rs_issue_queue
    import rs_issue_queue_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int TAG_W = 4,
    parameter int XLEN  = 32
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       alloc_valid_i,
    input  rs_scheduler_s              alloc_entry_i,
    output logic                       rs_full_o,
    output logic [$clog2(DEPTH):0]     count_o,
    input  logic                       cdb_valid_i,
    input  logic [TAG_W-1:0]           cdb_tag_i,
    input  logic [XLEN-1:0]            cdb_value_i,
    input  logic                       flush_i,
    output logic                       issue_valid_o,
    output rs_scheduler_s              issue_entry_o,
    input  logic                       issue_ready_i
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;
    localparam logic [TAG_W-1:0] NO_TAG = '1;

    logic [DEPTH-1:0]  valid_q, valid_d;
    rs_scheduler_s     entry_q [DEPTH];
    rs_scheduler_s     entry_d [DEPTH];
    logic [CNT_W-1:0]  count_q, count_d;
    logic              full_q, full_d;
    logic              issue_valid_q, issue_valid_d;
    rs_scheduler_s     issue_entry_q, issue_entry_d;

    logic [DEPTH-1:0]  ready;
    logic              free_found;
    logic [IDX_W-1:0]  free_idx;
    logic              sel_found;
    logic [IDX_W-1:0]  sel_idx;
    logic              stage_load;
    logic              do_alloc;
    logic              do_sel;

    // Broadcasts on the sentinel tag never match, so ready operands are safe.
    function automatic rs_scheduler_s wake(input rs_scheduler_s e);
        rs_scheduler_s r;
        r = e;
        if (cdb_valid_i && (cdb_tag_i != NO_TAG)) begin
            if (e.qj == cdb_tag_i) begin
                r.vj = cdb_value_i;
                r.qj = NO_TAG;
            end
            if (e.qk == cdb_tag_i) begin
                r.vk = cdb_value_i;
                r.qk = NO_TAG;
            end
        end
        return r;
    endfunction

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ready
            assign ready[gi] = valid_q[gi] && (entry_q[gi].qj == NO_TAG)
                                           && (entry_q[gi].qk == NO_TAG);
        end
    endgenerate

    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

`ifdef RS_OLDEST_FIRST_EN
    // age_q[i][j] set means entry j was allocated before entry i.
    logic [DEPTH-1:0] age_q [DEPTH];
    logic [DEPTH-1:0] age_d [DEPTH];
    logic [DEPTH-1:0] sel_mask;

    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ready[i] && ((age_q[i] & ready) == '0)) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
    end

    always_comb begin
        sel_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            age_d[i] = age_q[i];
        end
        if (do_sel) begin
            sel_mask[sel_idx] = 1'b1;
            for (int j = 0; j < DEPTH; j++) begin
                age_d[j][sel_idx] = 1'b0;
            end
            age_d[sel_idx] = '0;
        end
        if (do_alloc) begin
            for (int j = 0; j < DEPTH; j++) begin
                age_d[j][free_idx] = 1'b0;
            end
            age_d[free_idx] = valid_q & ~sel_mask;
        end
        if (flush_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                age_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                age_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                age_q[i] <= age_d[i];
            end
        end
    end
`else
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (ready[i]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
    end
`endif

    assign stage_load = !issue_valid_q || issue_ready_i;
    assign do_alloc   = alloc_valid_i && !full_q && !flush_i && free_found;
    assign do_sel     = stage_load && sel_found && !flush_i;

    always_comb begin
        valid_d       = valid_q;
        count_d       = count_q;
        issue_valid_d = issue_valid_q;
        issue_entry_d = issue_entry_q;
        for (int i = 0; i < DEPTH; i++) begin
            entry_d[i] = valid_q[i] ? wake(entry_q[i]) : entry_q[i];
        end

        if (do_sel) begin
            valid_d[sel_idx]      = 1'b0;
            issue_valid_d         = 1'b1;
            issue_entry_d         = entry_q[sel_idx];
            issue_entry_d.qj      = NO_TAG;
            issue_entry_d.qk      = NO_TAG;
        end else if (stage_load) begin
            issue_valid_d = 1'b0;
        end

        if (do_alloc) begin
            valid_d[free_idx] = 1'b1;
            entry_d[free_idx] = wake(alloc_entry_i);
        end

        count_d = count_q + CNT_W'(do_alloc) - CNT_W'(do_sel);

        if (flush_i) begin
            valid_d       = '0;
            issue_valid_d = 1'b0;
            count_d       = '0;
        end

        full_d = (count_d == CNT_W'(DEPTH));
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            valid_q       <= '0;
            count_q       <= '0;
            full_q        <= 1'b0;
            issue_valid_q <= 1'b0;
            issue_entry_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= '0;
            end
        end else begin
            valid_q       <= valid_d;
            count_q       <= count_d;
            full_q        <= full_d;
            issue_valid_q <= issue_valid_d;
            issue_entry_q <= issue_entry_d;
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= entry_d[i];
            end
        end
    end

    assign rs_full_o     = full_q;
    assign count_o       = count_q;
    assign issue_valid_o = issue_valid_q;
    assign issue_entry_o = issue_entry_q;

endmodule

`default_nettype wire

// File: tb/tb_rs_issue_queue.sv
// ============================================================================
// Module   : tb_rs_issue_queue
// Purpose  : Scoreboard-driven bench for rs_issue_queue (either select build).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rs_issue_queue;
    import rs_issue_queue_pkg::*;

    localparam logic [3:0] NT = 4'hF;

    logic          clk;
    logic          reset_i;
    logic          alloc_valid_i;
    rs_scheduler_s alloc_entry_i;
    logic          rs_full_o;
    logic [3:0]    count_o;
    logic          cdb_valid_i;
    logic [3:0]    cdb_tag_i;
    logic [31:0]   cdb_value_i;
    logic          flush_i;
    logic          issue_valid_o;
    rs_scheduler_s issue_entry_o;
    logic          issue_ready_i;

    int checks   = 0;
    int failures = 0;
    rs_scheduler_s exp_q[$];
    rs_scheduler_s exp_e;

    rs_issue_queue #(.DEPTH(8), .TAG_W(4), .XLEN(32)) dut (
        .clk_i         (clk),
        .reset_i       (reset_i),
        .alloc_valid_i (alloc_valid_i),
        .alloc_entry_i (alloc_entry_i),
        .rs_full_o     (rs_full_o),
        .count_o       (count_o),
        .cdb_valid_i   (cdb_valid_i),
        .cdb_tag_i     (cdb_tag_i),
        .cdb_value_i   (cdb_value_i),
        .flush_i       (flush_i),
        .issue_valid_o (issue_valid_o),
        .issue_entry_o (issue_entry_o),
        .issue_ready_i (issue_ready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic rs_scheduler_s mk(input logic [3:0] tag, input logic [3:0] qj,
                                         input logic [3:0] qk, input logic [31:0] vj,
                                         input logic [31:0] vk);
        rs_scheduler_s e;
        e = '0;
        e.rob_tag   = tag;
        e.qj        = qj;
        e.qk        = qk;
        e.vj        = vj;
        e.vk        = vk;
        e.store_imm = {28'h0, tag} + 32'h100;
        e.alu_ctrl  = tag ^ 4'h5;
        e.fu_type   = 3'd2;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_i = 1'b0;
        alloc_valid_i = 1'b0; alloc_entry_i = '0;
        cdb_valid_i = 1'b0; cdb_tag_i = '0; cdb_value_i = '0;
        flush_i = 1'b0; issue_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (issue_valid_o !== 1'b0 || issue_entry_o !== '0) begin
            failures++;
            $display("FAIL reset_issue: got valid=%b entry=%h, want 0/0", issue_valid_o, issue_entry_o);
        end
        checks++;
        if (rs_full_o !== 1'b0 || count_o !== 4'd0) begin
            failures++;
            $display("FAIL reset_count: got full=%b count=%0d, want 0/0", rs_full_o, count_o);
        end
        reset_i = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        rs_scheduler_s e;
        issue_ready_i = 1'b1;
        e = mk(4'd3, NT, NT, 32'h11, 32'h22);
        alloc_valid_i = 1'b1; alloc_entry_i = e; exp_q.push_back(e);
        tick();
        alloc_valid_i = 1'b0;
        checks++;
        if (count_o !== 4'd1 || issue_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL basic_n1: got count=%0d valid=%b, want 1/0", count_o, issue_valid_o);
        end
        tick();
        exp_e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        checks++;
        if (issue_valid_o !== 1'b1 || issue_entry_o !== exp_e || count_o !== 4'd0) begin
            failures++;
            $display("FAIL basic_issue: got valid=%b count=%0d entry=%h, want 1/0 %h",
                     issue_valid_o, count_o, issue_entry_o, exp_e);
        end
        tick();
        checks++;
        if (issue_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL basic_drain: got valid=%b, want 0", issue_valid_o);
        end
    endtask

    task automatic test_wakeup();
        rs_scheduler_s e;
        issue_ready_i = 1'b1;
        e = mk(4'd4, 4'd5, NT, 32'h0, 32'h33);
        alloc_valid_i = 1'b1; alloc_entry_i = e;
        tick();
        alloc_valid_i = 1'b0;
        tick(); tick();
        checks++;
        if (issue_valid_o !== 1'b0 || count_o !== 4'd1) begin
            failures++;
            $display("FAIL wake_wait: got valid=%b count=%0d, want 0/1", issue_valid_o, count_o);
        end
        cdb_valid_i = 1'b1; cdb_tag_i = 4'd5; cdb_value_i = 32'hDEADBEEF;
        e.vj = 32'hDEADBEEF; e.qj = NT; exp_q.push_back(e);
        tick();
        cdb_valid_i = 1'b0;
        checks++;
        if (issue_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL wake_early: got valid=%b one cycle after wake, want 0", issue_valid_o);
        end
        tick();
        exp_e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        checks++;
        if (issue_valid_o !== 1'b1 || issue_entry_o !== exp_e) begin
            failures++;
            $display("FAIL wake_issue: got valid=%b entry=%h, want 1 %h", issue_valid_o, issue_entry_o, exp_e);
        end
        tick();
        checks++;
        if (count_o !== 4'd0 || issue_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL wake_drain: got count=%0d valid=%b, want 0/0", count_o, issue_valid_o);
        end
    endtask

    task automatic test_alloc_wake();
        rs_scheduler_s e;
        issue_ready_i = 1'b1;
        e = mk(4'd6, NT, 4'd7, 32'h44, 32'h0);
        alloc_valid_i = 1'b1; alloc_entry_i = e;
        cdb_valid_i = 1'b1; cdb_tag_i = 4'd7; cdb_value_i = 32'h12;
        e.vk = 32'h12; e.qk = NT; exp_q.push_back(e);
        tick();
        alloc_valid_i = 1'b0; cdb_valid_i = 1'b0;
        checks++;
        if (count_o !== 4'd1 || issue_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL aw_alloc: got count=%0d valid=%b, want 1/0", count_o, issue_valid_o);
        end
        tick();
        exp_e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        checks++;
        if (issue_valid_o !== 1'b1 || issue_entry_o !== exp_e) begin
            failures++;
            $display("FAIL aw_issue: got valid=%b entry=%h, want 1 %h", issue_valid_o, issue_entry_o, exp_e);
        end
        tick();
    endtask

    task automatic test_full_stall();
        rs_scheduler_s s, e;
        issue_ready_i = 1'b0;
        s = mk(4'd1, NT, NT, 32'hA1, 32'hB1);
        alloc_valid_i = 1'b1; alloc_entry_i = s; exp_q.push_back(s);
        tick();
        alloc_valid_i = 1'b0;
        tick();
        checks++;
        if (issue_valid_o !== 1'b1 || issue_entry_o !== s || count_o !== 4'd0) begin
            failures++;
            $display("FAIL full_stage: got valid=%b count=%0d entry=%h, want 1/0 %h",
                     issue_valid_o, count_o, issue_entry_o, s);
        end
        for (int i = 0; i < 8; i++) begin
            e = mk(4'(i + 2), 4'hA, NT, 32'(i), 32'(100 + i));
            alloc_valid_i = 1'b1; alloc_entry_i = e;
            e.vj = 32'h5A5A5A5A; e.qj = NT; exp_q.push_back(e);
            tick();
            checks++;
            if (count_o !== 4'(i + 1) || issue_entry_o !== s || issue_valid_o !== 1'b1) begin
                failures++;
                $display("FAIL full_fill%0d: got count=%0d valid=%b entry=%h, want %0d/1 %h",
                         i, count_o, issue_valid_o, issue_entry_o, i + 1, s);
            end
        end
        checks++;
        if (rs_full_o !== 1'b1) begin
            failures++;
            $display("FAIL full_flag: got full=%b, want 1", rs_full_o);
        end
        // Ninth allocation is dropped; sentinel-tag broadcast must not touch ready operands.
        alloc_valid_i = 1'b1; alloc_entry_i = mk(4'hB, NT, NT, 32'hBB, 32'hBB);
        cdb_valid_i = 1'b1; cdb_tag_i = NT; cdb_value_i = 32'h0BAD0BAD;
        tick();
        alloc_valid_i = 1'b0; cdb_valid_i = 1'b0;
        checks++;
        if (count_o !== 4'd8 || rs_full_o !== 1'b1 || issue_entry_o !== s) begin
            failures++;
            $display("FAIL full_drop: got count=%0d full=%b entry=%h, want 8/1 %h",
                     count_o, rs_full_o, issue_entry_o, s);
        end
        cdb_valid_i = 1'b1; cdb_tag_i = 4'hA; cdb_value_i = 32'h5A5A5A5A;
        tick();
        cdb_valid_i = 1'b0;
        issue_ready_i = 1'b1;
        for (int k = 0; k < 9; k++) begin
            exp_e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
            checks++;
            if (issue_valid_o !== 1'b1 || issue_entry_o !== exp_e) begin
                failures++;
                $display("FAIL full_drain%0d: got valid=%b entry=%h, want 1 %h",
                         k, issue_valid_o, issue_entry_o, exp_e);
            end
            tick();
        end
        checks++;
        if (issue_valid_o !== 1'b0 || count_o !== 4'd0 || rs_full_o !== 1'b0) begin
            failures++;
            $display("FAIL full_empty: got valid=%b count=%0d full=%b, want 0/0/0",
                     issue_valid_o, count_o, rs_full_o);
        end
    endtask

    task automatic test_age_order();
        rs_scheduler_s a, b, c;
        issue_ready_i = 1'b1;
        a = mk(4'd1, 4'd6, NT, 32'h0, 32'h1);
        b = mk(4'd2, 4'd5, NT, 32'h0, 32'h2);
        c = mk(4'd9, 4'd5, NT, 32'h0, 32'h9);
        alloc_valid_i = 1'b1; alloc_entry_i = a;
        tick();
        alloc_entry_i = b;
        tick();
        alloc_valid_i = 1'b0;
        cdb_valid_i = 1'b1; cdb_tag_i = 4'd6; cdb_value_i = 32'h66;
        a.vj = 32'h66; a.qj = NT; exp_q.push_back(a);
        tick();
        cdb_valid_i = 1'b0;
        tick();
        exp_e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        checks++;
        if (issue_valid_o !== 1'b1 || issue_entry_o !== exp_e) begin
            failures++;
            $display("FAIL age_first: got valid=%b entry=%h, want 1 %h", issue_valid_o, issue_entry_o, exp_e);
        end
        alloc_valid_i = 1'b1; alloc_entry_i = c;
        tick();
        alloc_valid_i = 1'b0;
        checks++;
        if (issue_valid_o !== 1'b0 || count_o !== 4'd2) begin
            failures++;
            $display("FAIL age_refill: got valid=%b count=%0d, want 0/2", issue_valid_o, count_o);
        end
        b.vj = 32'h55; b.qj = NT;
        c.vj = 32'h55; c.qj = NT;
`ifdef RS_OLDEST_FIRST_EN
        exp_q.push_back(b); exp_q.push_back(c);
`else
        exp_q.push_back(c); exp_q.push_back(b);
`endif
        cdb_valid_i = 1'b1; cdb_tag_i = 4'd5; cdb_value_i = 32'h55;
        tick();
        cdb_valid_i = 1'b0;
        tick();
        for (int k = 0; k < 2; k++) begin
            exp_e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
            checks++;
            if (issue_valid_o !== 1'b1 || issue_entry_o !== exp_e) begin
                failures++;
                $display("FAIL age_order%0d: got valid=%b tag=%h, want 1 tag=%h",
                         k, issue_valid_o, issue_entry_o.rob_tag, exp_e.rob_tag);
            end
            tick();
        end
        checks++;
        if (issue_valid_o !== 1'b0 || count_o !== 4'd0) begin
            failures++;
            $display("FAIL age_empty: got valid=%b count=%0d, want 0/0", issue_valid_o, count_o);
        end
    endtask

    task automatic test_flush();
        issue_ready_i = 1'b0;
        alloc_valid_i = 1'b1; alloc_entry_i = mk(4'hE, NT, NT, 32'hE0, 32'hE1);
        tick();
        for (int i = 0; i < 5; i++) begin
            alloc_entry_i = mk(4'(i), 4'hC, NT, 32'(i), 32'(i));
            tick();
        end
        alloc_valid_i = 1'b0;
        checks++;
        if (count_o !== 4'd5 || issue_valid_o !== 1'b1) begin
            failures++;
            $display("FAIL flush_pre: got count=%0d valid=%b, want 5/1", count_o, issue_valid_o);
        end
        flush_i = 1'b1; issue_ready_i = 1'b1;
        alloc_valid_i = 1'b1; alloc_entry_i = mk(4'hD, NT, NT, 32'hD0, 32'hD1);
        tick();
        flush_i = 1'b0; alloc_valid_i = 1'b0;
        checks++;
        if (count_o !== 4'd0 || issue_valid_o !== 1'b0 || rs_full_o !== 1'b0) begin
            failures++;
            $display("FAIL flush_post: got count=%0d valid=%b full=%b, want 0/0/0",
                     count_o, issue_valid_o, rs_full_o);
        end
        cdb_valid_i = 1'b1; cdb_tag_i = 4'hC; cdb_value_i = 32'h77;
        tick();
        cdb_valid_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (issue_valid_o !== 1'b0 || count_o !== 4'd0) begin
                failures++;
                $display("FAIL flush_ghost%0d: got valid=%b count=%0d tag=%h, want 0/0",
                         k, issue_valid_o, count_o, issue_entry_o.rob_tag);
            end
            tick();
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_left: got %0d pending, want 0", exp_q.size());
        end
    endtask

    task automatic test_async_reset();
        issue_ready_i = 1'b0;
        alloc_valid_i = 1'b1; alloc_entry_i = mk(4'd5, 4'hC, NT, 32'h5, 32'h5);
        tick();
        alloc_valid_i = 1'b0;
        checks++;
        if (count_o !== 4'd1) begin
            failures++;
            $display("FAIL areset_pre: got count=%0d, want 1", count_o);
        end
        #2 reset_i = 1'b0;
        #1;
        checks++;
        if (count_o !== 4'd0 || issue_valid_o !== 1'b0 || issue_entry_o !== '0) begin
            failures++;
            $display("FAIL areset_now: got count=%0d valid=%b entry=%h, want 0/0/0",
                     count_o, issue_valid_o, issue_entry_o);
        end
        tick();
        reset_i = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wakeup();
        test_alloc_wake();
        test_full_stall();
        test_age_order();
        test_flush();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
